// File: rtl/blink_core_scheduler.sv
// rtl/blink_core_scheduler.sv - round-robin sequencer sharing one combinational Blink-128 core; BLINK_SCHED_STATS_EN adds ops_done/stall_cycles
module blink_core_scheduler #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_wr_valid,
  input  logic [1279:0]        key_wr_data,
  output logic                 key_wr_ready,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_enc,
  input  logic [128*NREQ-1:0]  req_p,
  input  logic [128*NREQ-1:0]  req_t,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [127:0]         rsp_data,
  input  logic                 rsp_ready,
  output logic                 core_enc,
  output logic [127:0]         core_p,
  output logic [127:0]         core_t,
  output logic [1279:0]        core_k0,
  input  logic [127:0]         core_c,
  output logic                 busy
`ifdef BLINK_SCHED_STATS_EN
  ,
  output logic [31:0]          ops_done,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] rot;
  logic            grant_hit;
  logic [IDW:0]    g_sum;
  logic [IDW-1:0]  grant_idx;
  logic            grant_fire;
  logic            key_fire;

  // Rotate the request vector so bit 0 is rr_ptr, take the lowest set bit, map back to a requester index
  always_comb begin
    rot       = NREQ'({req_valid, req_valid} >> rr_ptr);
    grant_hit = 1'b0;
    g_sum     = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        grant_hit = 1'b1;
        g_sum     = {1'b0, rr_ptr} + (IDW+1)'(j);
      end
    end
    if (g_sum >= (IDW+1)'(NREQ)) begin
      g_sum = g_sum - (IDW+1)'(NREQ);
    end
    grant_idx = g_sum[IDW-1:0];
  end

  // Key load wins over a grant in the same IDLE cycle; both handshakes are combinational
  assign key_fire     = (state == IDLE) && key_wr_valid;
  assign grant_fire   = (state == IDLE) && !key_wr_valid && grant_hit;
  assign key_wr_ready = key_fire;
  assign req_ready    = grant_fire ? (NREQ'(1) << grant_idx) : '0;
  assign busy         = (state != IDLE);

  // Sequencer: capture job into core drive registers, hold for the settle window, then present C
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      cnt       <= '0;
      core_enc  <= 1'b0;
      core_p    <= '0;
      core_t    <= '0;
      core_k0   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_fire) begin
            core_k0 <= key_wr_data;
          end else if (grant_fire) begin
            core_enc <= req_enc[grant_idx];
            core_p   <= req_p[grant_idx*128 +: 128];
            core_t   <= req_t[grant_idx*128 +: 128];
            id_q     <= grant_idx;
            cnt      <= CW'(SETTLE);
            rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_data  <= core_c;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BLINK_SCHED_STATS_EN
  // Completed-response and back-pressure counters, both free-running with natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done     <= '0;
      stall_cycles <= '0;
    end else begin
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 32'd1;
      if (rsp_valid && !rsp_ready) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_blink_core_scheduler.sv
// tb/tb_blink_core_scheduler.sv - scoreboard bench for blink_core_scheduler with a stand-in Blink-128 core
module tb_blink_core_scheduler;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int SETTLE = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                key_wr_valid;
  logic [1279:0]       key_wr_data;
  logic                key_wr_ready;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_enc;
  logic [128*NREQ-1:0] req_p;
  logic [128*NREQ-1:0] req_t;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [127:0]        rsp_data;
  logic                rsp_ready;
  logic                core_enc;
  logic [127:0]        core_p;
  logic [127:0]        core_t;
  logic [1279:0]       core_k0;
  logic [127:0]        core_c;
  logic                busy;
`ifdef BLINK_SCHED_STATS_EN
  logic [31:0]         ops_done;
  logic [31:0]         stall_cycles;
`endif

  blink_core_scheduler #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .key_wr_valid(key_wr_valid), .key_wr_data(key_wr_data), .key_wr_ready(key_wr_ready),
    .req_valid(req_valid), .req_enc(req_enc), .req_p(req_p), .req_t(req_t), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .core_enc(core_enc), .core_p(core_p), .core_t(core_t), .core_k0(core_k0), .core_c(core_c),
    .busy(busy)
`ifdef BLINK_SCHED_STATS_EN
    , .ops_done(ops_done), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the combinational Blink-128 core: any key/tweak-dependent mixing will do
  function automatic logic [127:0] blink_ref(input logic enc, input logic [127:0] p,
                                             input logic [127:0] t, input logic [1279:0] k);
    logic [127:0] s;
    s = p ^ t;
    for (int r = 0; r < 10; r++) begin
      s = {s[94:0], s[127:95]} ^ k[r*128 +: 128];
      s = enc ? s + t : s - t;
    end
    return s;
  endfunction

  assign core_c = blink_ref(core_enc, core_p, core_t, core_k0);

  typedef struct {
    logic [IDW-1:0] id;
    logic [127:0]   data;
    int             due;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  bit            m_busy = 0;
  int            m_due = 0;
  int            m_rr = 0;
  logic [1279:0] m_key = '0;
  logic [127:0]  m_p = '0;
  logic [127:0]  m_t = '0;
  logic          prev_valid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one call per cycle at the negedge, inputs already stable for the coming edge
  task automatic model_step();
    int g;
    logic [NREQ-1:0] er;
    if (rst) begin
      q.delete();
      m_busy = 0;
      m_rr   = 0;
      m_key  = '0;
      return;
    end
    check("busy", busy, m_busy);
    check("core_k0_lo", core_k0[127:0], m_key[127:0]);
    check("core_k0_hi", core_k0[1279:1152], m_key[1279:1152]);
    if (!m_busy) begin
      if (key_wr_valid) begin
        check("key_wr_ready_load", key_wr_ready, 1'b1);
        check("req_ready_on_key", req_ready, '0);
        m_key = key_wr_data;
      end else if (|req_valid) begin
        g = -1;
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        er = '0;
        er[g] = 1'b1;
        check("req_ready_grant", req_ready, er);
        check("key_wr_ready_grant", key_wr_ready, 1'b0);
        m_p = req_p[g*128 +: 128];
        m_t = req_t[g*128 +: 128];
        q.push_back('{id: IDW'(g), data: blink_ref(req_enc[g], m_p, m_t, m_key), due: cyc + 1 + SETTLE});
        m_busy = 1;
        m_due  = cyc + 1 + SETTLE;
        m_rr   = (g + 1) % NREQ;
      end else begin
        check("req_ready_idle", req_ready, '0);
        check("key_wr_ready_idle", key_wr_ready, 1'b0);
      end
    end else begin
      check("req_ready_busy", req_ready, '0);
      check("key_wr_ready_busy", key_wr_ready, 1'b0);
      check("core_p_held", core_p, m_p);
      check("core_t_held", core_t, m_t);
      if (cyc >= m_due && rsp_ready) m_busy = 0;
    end
  endtask

  // Monitor: compare every presented response against the scoreboard head
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp_valid", rsp_valid, 1'b0);
      end else begin
        check("rsp_id", rsp_id, q[0].id);
        check("rsp_data", rsp_data, q[0].data);
        if (!prev_valid) check("rsp_latency_cycle", 128'(cyc), 128'(q[0].due));
        if (rsp_ready) void'(q.pop_front());
      end
    end
    prev_valid <= rsp_valid;
  end

  function automatic logic [1279:0] rand_key();
    logic [1279:0] k;
    for (int w = 0; w < 40; w++) k[w*32 +: 32] = $urandom();
    return k;
  endfunction

  task automatic randomize_fields();
    for (int w = 0; w < 4*NREQ; w++) begin
      req_p[w*32 +: 32] = $urandom();
      req_t[w*32 +: 32] = $urandom();
    end
    req_enc = NREQ'($urandom());
  endtask

  task automatic drive(input logic r, input logic kv, input logic [1279:0] kd,
                       input logic [NREQ-1:0] rv, input logic rdy, input bit rnd);
    @(posedge clk);
    #1;
    rst          = r;
    key_wr_valid = kv;
    key_wr_data  = kd;
    req_valid    = rv;
    rsp_ready    = rdy;
    if (rnd) randomize_fields();
    @(negedge clk);
    model_step();
  endtask

  task automatic drain();
    for (int k = 0; k < SETTLE + 10 && m_busy; k++) drive(0, 0, '0, '0, 1, 1);
    drive(0, 0, '0, '0, 1, 1);
    check("drain_busy", busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_core_enc", core_enc, 1'b0);
    check("rst_core_p", core_p, '0);
    check("rst_core_t", core_t, '0);
    check("rst_core_k0_lo", core_k0[127:0], '0);
    check("rst_core_k0_hi", core_k0[1279:1152], '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_key_wr_ready", key_wr_ready, 1'b0);
    check("rst_req_ready", req_ready, '0);
    check("rst_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; key_wr_valid = 1'b0; key_wr_data = '0; req_valid = '0;
    req_enc = '0; req_p = '0; req_t = '0; rsp_ready = 1'b0;

    drive(1, 0, '0, '0, 0, 0);
    drive(1, 0, '0, '0, 0, 0);
    check_reset_outputs();

    // All-zero key load, then a random key
    drive(0, 1, '0, '0, 1, 0);
    drive(0, 0, '0, '0, 1, 0);
    drive(0, 1, rand_key(), '0, 1, 0);
    drive(0, 0, '0, '0, 1, 0);

    // Single directed job on requester 2
    req_enc = 4'b0100;
    req_p   = '0;
    req_t   = '0;
    req_p[2*128 +: 128] = 128'h0123456789abcdeffedcba9876543210;
    drive(0, 0, '0, 4'b0100, 1, 0);
    drain();

    // All requesters held valid: rotation 3,0,1,2,... continues from rr_ptr=3
    for (int k = 0; k < 5*(SETTLE+2); k++) drive(0, 0, '0, 4'b1111, 1, 1);
    drain();

    // Key load and request in the same idle cycle
    drive(0, 1, rand_key(), 4'b0001, 1, 1);
    drive(0, 0, '0, 4'b0001, 1, 1);
    drain();

    // Back-pressure: response held 10+ cycles while others request
    drive(0, 0, '0, 4'b0010, 0, 1);
    for (int k = 0; k < SETTLE + 10; k++) drive(0, 0, '0, 4'b1111, 0, 1);
    drive(0, 0, '0, 4'b1111, 1, 1);
    drain();

    // Reset while the settle counter reads 3
    drive(0, 0, '0, 4'b1000, 1, 1);
    for (int k = 0; k < SETTLE - 3; k++) drive(0, 0, '0, '0, 1, 1);
    drive(1, 0, '0, '0, 1, 0);
    drive(0, 0, '0, '0, 1, 0);
    check_reset_outputs();
    for (int k = 0; k < SETTLE + 4; k++) drive(0, 0, '0, '0, 1, 0);
    drive(0, 0, '0, 4'b1111, 1, 1);
    drain();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic kv;
      kv = ($urandom_range(0, 19) == 0);
      drive(0, kv, kv ? rand_key() : '0, NREQ'($urandom()), ($urandom_range(0, 3) != 0), 1);
    end
    drain();
    check("scoreboard_empty", 128'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
